sn74ls669_seq: RTL and testbench

Sequencer for a cascade of sn74ls669 up/down counters: it generates LOADn, U_Dn, ENABLE_Pn, ENABLE_Tn and DATA into the counters and reads back their Q and RCOn. On a start request it loads a start value, enables counting for exactly a requested number of clocks in a chosen direction, then reports completion. It sits between the core's control logic and a chain of counters that all share CLOCK.

---
 rtl/sn74ls669_seq.sv | 142 ++++++++++++++
 tb/tb_sn74ls669_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sn74ls669_seq.sv
// Load/count/complete sequencer for a cascade of sn74ls669 4-bit up/down counters.
// Optional Q_IN shadow checker is built when SN74LS669_SEQ_CHECK_EN is defined.
module sn74ls669_seq #(
   parameter int STAGES = 2
) (
   input  logic                  CLOCK,
   input  logic                  RESETn,
   input  logic                  START,
   input  logic                  DIR,
   input  logic [4*STAGES-1:0]   START_VAL,
   input  logic [4*STAGES-1:0]   STEPS,
   input  logic [4*STAGES-1:0]   Q_IN,
   input  logic                  RCOn_IN,
   output logic                  LOADn,
   output logic                  U_Dn,
   output logic                  ENABLE_Pn,
   output logic                  ENABLE_Tn,
   output logic [4*STAGES-1:0]   DATA,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  WRAP,
   output logic                  ERR,
   output logic [1:0]            state_dbg
);

   localparam int W = 4 * STAGES;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic          start_q;
   logic          accept;
   logic          dir_q;
   logic [W-1:0]  val_q;
   logic [W-1:0]  rem_q;

   // A request is taken once; the following IDLE cycle launches LOAD so the
   // counters load two edges after START is sampled.
   assign accept    = (state == S_IDLE) && START && !start_q;
   assign state_dbg = state;

   always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_q) state_nx = S_LOAD;
         S_LOAD:  state_nx = (rem_q != '0) ? S_RUN : S_DONE;
         S_RUN:   if (rem_q == W'(1)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
         start_q <= 1'b0;
         dir_q   <= 1'b1;
         val_q   <= '0;
         rem_q   <= '0;
         WRAP    <= 1'b0;
      end else begin
         start_q <= accept;
         if (accept) begin
            dir_q <= DIR;
            val_q <= START_VAL;
            rem_q <= STEPS;
            WRAP  <= 1'b0;
         end else if (state == S_RUN) begin
            rem_q <= rem_q - W'(1);
            // RCOn low in a RUN cycle means this edge carries the chain over
            if (!RCOn_IN) WRAP <= 1'b1;
         end
      end
   end

   // Outputs are registered from the next state so they track the FSM exactly.
   always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
         LOADn     <= 1'b1;
         U_Dn      <= 1'b1;
         ENABLE_Pn <= 1'b1;
         ENABLE_Tn <= 1'b1;
         DATA      <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         LOADn     <= (state_nx != S_LOAD);
         ENABLE_Pn <= (state_nx != S_RUN);
         ENABLE_Tn <= (state_nx != S_RUN);
         BUSY      <= (state_nx == S_LOAD) || (state_nx == S_RUN);
         DONE      <= (state_nx == S_DONE);
         if (state_nx == S_LOAD) begin
            DATA <= val_q;
            U_Dn <= dir_q;
         end
      end
   end

`ifdef SN74LS669_SEQ_CHECK_EN
   logic [W-1:0] shadow_q;
   logic         err_q;

   // Shadow follows the chain: loaded on the load edge, stepped on each count edge.
   always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == S_LOAD) begin
            shadow_q <= val_q;
         end else if (state == S_RUN) begin
            shadow_q <= dir_q ? shadow_q + W'(1) : shadow_q - W'(1);
         end
         if (accept) begin
            err_q <= 1'b0;
         end else if (((state == S_RUN) || (state == S_DONE)) && (Q_IN != shadow_q)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign ERR = err_q;
`else
   logic unused_q_in;
   assign unused_q_in = ^Q_IN;
   assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_sn74ls669_seq.sv
// Randomized bench for sn74ls669_seq with a behavioural counter chain and
// an arithmetic reference model of the final value, wrap and shadow-error flags.
module tb_sn74ls669_seq;

   localparam int STAGES = 2;
   localparam int W      = 4 * STAGES;

   logic          clk;
   logic          RESETn;
   logic          START;
   logic          DIR;
   logic [W-1:0]  START_VAL;
   logic [W-1:0]  STEPS;
   logic [W-1:0]  Q_IN;
   logic          RCOn_IN;
   logic          LOADn;
   logic          U_Dn;
   logic          ENABLE_Pn;
   logic          ENABLE_Tn;
   logic [W-1:0]  DATA;
   logic          BUSY;
   logic          DONE;
   logic          WRAP;
   logic          ERR;
   logic [1:0]    state_dbg;

   logic [W-1:0]  chain_q = '0;
   logic [W-1:0]  fault_mask = '0;
   logic [W-1:0]  exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;

   sn74ls669_seq #(.STAGES(STAGES)) dut (
      .CLOCK(clk), .RESETn(RESETn), .START(START), .DIR(DIR),
      .START_VAL(START_VAL), .STEPS(STEPS), .Q_IN(Q_IN), .RCOn_IN(RCOn_IN),
      .LOADn(LOADn), .U_Dn(U_Dn), .ENABLE_Pn(ENABLE_Pn), .ENABLE_Tn(ENABLE_Tn),
      .DATA(DATA), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP), .ERR(ERR),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counter chain: synchronous load, count when both enables low
   always @(posedge clk) begin
      if (LOADn === 1'b0) chain_q <= DATA;
      else if (ENABLE_Pn === 1'b0 && ENABLE_Tn === 1'b0)
         chain_q <= (U_Dn === 1'b1) ? chain_q + W'(1) : chain_q - W'(1);
   end
   assign Q_IN    = chain_q & ~fault_mask;
   assign RCOn_IN = !((ENABLE_Tn === 1'b0) &&
                      ((U_Dn === 1'b1) ? (chain_q == {W{1'b1}}) : (chain_q == '0)));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model
   function automatic logic [W-1:0] model_final(input logic d, input logic [W-1:0] v, input int n);
      int r;
      r = d ? int'(v) + n : int'(v) - n;
      return W'(r);
   endfunction

   function automatic logic model_wrap(input logic d, input logic [W-1:0] v, input int n);
      if (d) return (int'(v) + n) > ((1 << W) - 1);
      return n > int'(v);
   endfunction

   function automatic logic model_err(input logic d, input logic [W-1:0] v, input int n,
                                      input logic [W-1:0] mask);
      logic e;
      e = 1'b0;
`ifdef SN74LS669_SEQ_CHECK_EN
      for (int j = 0; j <= n; j++)
         if ((model_final(d, v, j) & mask) != '0) e = 1'b1;
`else
      if (d && v == '0 && n < 0 && mask == '0) e = 1'b0;
`endif
      return e;
   endfunction

   // driver: called at a negedge; START is sampled at the next posedge (edge 0)
   task automatic run_op(input logic d, input logic [W-1:0] v, input int n,
                         input logic hold, input logic [W-1:0] mask);
      int loads, ld_at, ens, ents, en_first, busy_n, done_at, dones, stop_at;
      logic exp_wrap, exp_err;
      exp_q.push_back(model_final(d, v, n) & ~mask);
      exp_wrap = model_wrap(d, v, n);
      exp_err  = model_err(d, v, n, mask);
      fault_mask = mask;
      START = 1'b1; DIR = d; START_VAL = v; STEPS = W'(n);
      loads = 0; ld_at = -1; ens = 0; ents = 0; en_first = -1;
      busy_n = 0; done_at = -1; dones = 0; stop_at = -1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!LOADn) begin loads++; ld_at = k; end
         if (!ENABLE_Pn) begin ens++; if (en_first < 0) en_first = k; end
         if (!ENABLE_Tn) ents++;
         if (BUSY) busy_n++;
         if (DONE) begin dones++; if (done_at < 0) done_at = k; end
         if (k == 0 && !hold) begin
            START = 1'b0; DIR = 1'($urandom_range(0, 1));
            START_VAL = W'($urandom); STEPS = W'($urandom);
         end
         if (done_at >= 0 && stop_at < 0) stop_at = done_at + (hold ? 2 : 1);
         if (hold && k == done_at + 1 && done_at >= 0) START = 1'b0;
         if (k == stop_at) break;
      end
      START = 1'b0;
      check("op_timeout", 32'(done_at >= 0), 32'd1);
      check("load_pulses", 32'(loads), 32'd1);
      check("load_at", 32'(ld_at), 32'd1);
      check("enp_cycles", 32'(ens), 32'(n));
      check("ent_cycles", 32'(ents), 32'(n));
      if (n != 0) check("en_first", 32'(en_first), 32'd2);
      check("busy_cycles", 32'(busy_n), 32'(n + 1));
      check("done_at", 32'(done_at), 32'(n + 2));
      check("done_pulses", 32'(dones), 32'd1);
      check("busy_after", 32'(BUSY), 32'd0);
      check("q_final", 32'(Q_IN), 32'(exp_q.pop_front()));
      check("wrap", 32'(WRAP), 32'(exp_wrap));
      check("err", 32'(ERR), 32'(exp_err));
      fault_mask = '0;
   endtask

   // reset asserted so that the last count before reset leaves two undone
   task automatic run_reset_mid(input logic d, input logic [W-1:0] v, input int n);
      int ens;
      logic hit;
      START = 1'b1; DIR = d; START_VAL = v; STEPS = W'(n);
      ens = 0; hit = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (k == 0) START = 1'b0;
         if (!ENABLE_Pn) begin
            ens++;
            if (ens == n - 2) begin RESETn = 1'b0; hit = 1'b1; break; end
         end
      end
      check("rst_reached", 32'(hit), 32'd1);
      @(negedge clk);
      check("rst_enp", 32'(ENABLE_Pn), 32'd1);
      check("rst_ent", 32'(ENABLE_Tn), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_loadn", 32'(LOADn), 32'd1);
      check("rst_data", 32'(DATA), 32'd0);
      check("rst_udn", 32'(U_Dn), 32'd1);
      RESETn = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_q_frozen", 32'(Q_IN), 32'(model_final(d, v, n - 2)));
      check("rst_wrap", 32'(WRAP), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESETn = 1'b0; START = 1'b0; DIR = 1'b1; START_VAL = '0; STEPS = '0;
      repeat (3) @(negedge clk);
      check("reset_loadn", 32'(LOADn), 32'd1);
      check("reset_udn", 32'(U_Dn), 32'd1);
      check("reset_enp", 32'(ENABLE_Pn), 32'd1);
      check("reset_ent", 32'(ENABLE_Tn), 32'd1);
      check("reset_data", 32'(DATA), 32'd0);
      check("reset_busy", 32'(BUSY), 32'd0);
      check("reset_done", 32'(DONE), 32'd0);
      check("reset_wrap", 32'(WRAP), 32'd0);
      check("reset_err", 32'(ERR), 32'd0);
      RESETn = 1'b1;
      @(negedge clk);

      run_op(1'b1, 8'h10, 5, 1'b0, '0);
      run_op(1'b0, 8'h02, 4, 1'b0, '0);
      run_op(1'b1, 8'hA5, 0, 1'b0, '0);
      run_op(1'b1, 8'h30, 6, 1'b1, '0);
      run_reset_mid(1'b1, 8'h40, 7);
      @(negedge clk);
      run_op(1'b1, 8'h00, 4, 1'b0, 8'h01);
      run_op(1'b1, 8'hFE, 3, 1'b0, '0);
      run_op(1'b0, 8'h00, 1, 1'b0, '0);
      run_op(1'b1, 8'hFF, 1, 1'b1, '0);

      for (int i = 0; i < 25; i++) begin
         run_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                int'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0), '0);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
